// File: rtl/tx_fifo_ctrl.sv
// Single-clock FIFO controller: owns pointers, occupancy and status flags, and
// drives an external asynchronous-read dp_ram so the head word falls through.
module tx_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int RAM_DEPTH     = 1024,
  parameter int AFULL_THRESH  = 1020,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_ram_wen,
  output logic [ADDR_WIDTH-1:0] o_ram_waddr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_ren,
  output logic [ADDR_WIDTH-1:0] o_ram_raddr,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam logic [ADDR_WIDTH:0] LVL_FULL   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Request/accept semantics: i_wr and i_rd act as valid, ~o_full and ~o_empty
  // act as ready; a request is taken in the same cycle only when both are high,
  // otherwise it is dropped and flagged. Reset masks both strobes.
  assign wr_ok = i_wr & ~o_full  & ~i_rst;
  assign rd_ok = i_rd & ~o_empty & ~i_rst;

  assign o_ram_wen   = wr_ok;
  assign o_ram_waddr = wptr;
  assign o_ram_wdata = i_wdata;
  assign o_ram_ren   = rd_ok;
  assign o_ram_raddr = rptr;
  assign o_rdata     = i_ram_rdata;

  assign o_level     = level;
  assign o_full      = (level == LVL_FULL);
  assign o_empty     = (level == '0);
  assign o_afull     = (level >= LVL_AFULL);
  assign o_aempty    = (level <= LVL_AEMPTY);
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overflow_q  <= i_wr & o_full;
      underflow_q <= i_rd & o_empty;
    end
  end

endmodule
